// File: rtl/arp_rx_parser.sv
// arp_rx_parser: parses ARP frames from MAC RX beats, queues one reply for the ARP sender, reports peer replies.
// Define ARP_RX_DA_FILTER_EN to accept only frames addressed to LOCAL_MAC or broadcast.
module arp_rx_parser #(
    parameter logic [47:0] LOCAL_MAC = 48'h00_0A_35_00_01_02
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] Local_IP,
    input  logic [31:0] Mac_rx_data,
    input  logic [1:0]  Mac_rx_mod,
    input  logic        Mac_rx_sop,
    input  logic        Mac_rx_eop,
    input  logic        Mac_rx_valid,
    input  logic        Arp_tx_sop,
    input  logic        Arp_tx_eop,
    output logic        StartARPSend,
    output logic        StartARPACK,
    output logic [47:0] DST_MAC,
    output logic [31:0] Dst_IP,
    output logic        Arp_resolved_valid,
    output logic [47:0] Arp_resolved_mac,
    output logic [31:0] Arp_resolved_ip,
    output logic [7:0]  Arp_drop_cnt
);
    localparam logic [1:0] RX_IDLE = 2'd0, RX_HDR = 2'd1, RX_DRAIN = 2'd2;
    localparam logic [1:0] TX_IDLE = 2'd0, TX_REQ = 2'd1, TX_BUSY = 2'd2;

    logic [1:0]  rx_state, tx_state;
    logic [3:0]  idx;
    logic [15:0] da_hi, oper;
    logic [47:0] sha, act_mac, pend_mac, a1_mac, n_act_mac, n_pend_mac;
    logic [31:0] spa, act_ip, pend_ip, a1_ip, n_act_ip, n_pend_ip;
    logic        act_v, pend_v, a1_v, p1_v, n_act_v, n_pend_v;
    logic        hdr_beat, da_bad, chk_bad, last, eval_ok, enq, rep;
    logic        freeing, shift, to_act, to_pend, drop, launch, unused;

`ifdef ARP_RX_DA_FILTER_EN
    assign da_bad = idx == 4'd1 && {da_hi, Mac_rx_data} != LOCAL_MAC
                    && {da_hi, Mac_rx_data} != 48'hFFFF_FFFF_FFFF;
    assign unused = ^Mac_rx_mod;
`else
    assign da_bad = 1'b0;
    assign unused = ^{Mac_rx_mod, da_hi, LOCAL_MAC};
`endif

    assign StartARPACK = 1'b1;
    assign hdr_beat = Mac_rx_valid && !Mac_rx_sop && rx_state == RX_HDR;
    assign last     = idx == 4'd10;
    assign chk_bad  = da_bad
                    || (idx == 4'd3 && Mac_rx_data[15:0] != 16'h0806)
                    || (idx == 4'd4 && Mac_rx_data != 32'h0001_0800)
                    || (idx == 4'd5 && Mac_rx_data[31:16] != 16'h0604)
                    || (last && Mac_rx_data != Local_IP);
    assign eval_ok  = hdr_beat && last && !chk_bad;
    assign enq      = eval_ok && oper == 16'd1;
    assign rep      = eval_ok && oper == 16'd2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            idx      <= 4'd0;
            da_hi    <= 16'd0;
            oper     <= 16'd0;
            sha      <= 48'd0;
            spa      <= 32'd0;
        end else if (Mac_rx_valid) begin
            if (Mac_rx_sop) begin
                rx_state <= Mac_rx_eop ? RX_IDLE : RX_HDR;
                idx      <= 4'd1;
                da_hi    <= Mac_rx_data[15:0];
            end else if (rx_state == RX_HDR) begin
                idx      <= idx + 4'd1;
                rx_state <= (chk_bad || last || Mac_rx_eop) ? (Mac_rx_eop ? RX_IDLE : RX_DRAIN) : RX_HDR;
                if (idx == 4'd5) oper <= Mac_rx_data[15:0];
                if (idx == 4'd6) sha[47:16] <= Mac_rx_data;
                if (idx == 4'd7) {sha[15:0], spa[31:16]} <= Mac_rx_data;
                if (idx == 4'd8) spa[15:0] <= Mac_rx_data[31:16];
            end else if (rx_state == RX_DRAIN && Mac_rx_eop) begin
                rx_state <= RX_IDLE;
            end
        end
    end

    // Free and pending shift resolve first so a same-cycle enqueue lands behind them.
    always_comb begin
        freeing    = tx_state == TX_BUSY && Arp_tx_eop;
        shift      = freeing && pend_v;
        a1_v       = (act_v && !freeing) || shift;
        a1_mac     = shift ? pend_mac : act_mac;
        a1_ip      = shift ? pend_ip : act_ip;
        p1_v       = pend_v && !shift;
        to_act     = enq && !a1_v;
        to_pend    = enq && a1_v && !p1_v;
        drop       = enq && a1_v && p1_v;
        n_act_v    = a1_v || enq;
        n_act_mac  = to_act ? sha : a1_mac;
        n_act_ip   = to_act ? spa : a1_ip;
        n_pend_v   = p1_v || to_pend;
        n_pend_mac = to_pend ? sha : pend_mac;
        n_pend_ip  = to_pend ? spa : pend_ip;
        launch     = (tx_state == TX_IDLE || freeing) && n_act_v;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state           <= TX_IDLE;
            act_v              <= 1'b0;
            act_mac            <= 48'd0;
            act_ip             <= 32'd0;
            pend_v             <= 1'b0;
            pend_mac           <= 48'd0;
            pend_ip            <= 32'd0;
            StartARPSend       <= 1'b0;
            DST_MAC            <= 48'd0;
            Dst_IP             <= 32'd0;
            Arp_drop_cnt       <= 8'd0;
            Arp_resolved_valid <= 1'b0;
            Arp_resolved_mac   <= 48'd0;
            Arp_resolved_ip    <= 32'd0;
        end else begin
            act_v              <= n_act_v;
            act_mac            <= n_act_mac;
            act_ip             <= n_act_ip;
            pend_v             <= n_pend_v;
            pend_mac           <= n_pend_mac;
            pend_ip            <= n_pend_ip;
            Arp_resolved_valid <= rep;
            if (rep) begin
                Arp_resolved_mac <= sha;
                Arp_resolved_ip  <= spa;
            end
            if (drop && Arp_drop_cnt != 8'hFF) Arp_drop_cnt <= Arp_drop_cnt + 8'd1;
            if (launch) begin
                tx_state     <= TX_REQ;
                StartARPSend <= 1'b1;
                DST_MAC      <= n_act_mac;
                Dst_IP       <= n_act_ip;
            end else if (tx_state == TX_REQ && Arp_tx_sop) begin
                tx_state     <= TX_BUSY;
                StartARPSend <= 1'b0;
            end else if (freeing) begin
                tx_state     <= TX_IDLE;
            end
        end
    end
endmodule
